// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared op codes, FSM state type and width defaults for the
//               shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMT_W = 4;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shifter.sv
// ============================================================================
// Module      : shifter
// Description : Combinational single-step shifter (none / LSL / LSR / ASR).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        case (shift)
            SH_LSL:  out = {in[WIDTH-2:0], 1'b0};
            SH_LSR:  out = {1'b0, in[WIDTH-1:1]};
            SH_ASR:  out = {in[WIDTH-1], in[WIDTH-1:1]};
            default: out = in;
        endcase
    end

endmodule : shifter

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-step shift controller; iterates the single-step shifter
//               once per clock for 0..2**AMT_W-1 steps, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] w_shifted;

    // The shifter is driven from the registered op so mid-operation changes
    // on the shift port cannot corrupt the result.
    shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .in    (r_acc),
        .shift (r_op),
        .out   (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if ((amount == '0) || (shift == SH_NONE)) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_op  <= SH_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= in;
                        r_op  <= shift;
                        r_cnt <= amount;
                    end
                end
                SHIFT: begin
                    r_acc <= w_shifted;
                    r_cnt <= r_cnt - AMT_W'(1);
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign busy = (r_state == SHIFT) || (r_state == DONE);
    assign done = (r_state == DONE);
    assign out  = r_acc;

endmodule : shift_sequencer

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Scoreboard bench for shift_sequencer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] in_v;
    logic [1:0]  shift_v;
    logic [3:0]  amount_v;
    logic        busy;
    logic        done;
    logic [15:0] out_v;

    shift_sequencer #(
        .WIDTH (16),
        .AMT_W (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in_v),
        .shift  (shift_v),
        .amount (amount_v),
        .busy   (busy),
        .done   (done),
        .out    (out_v)
    );

    typedef struct {
        logic [15:0] res;
        int          done_cyc;
        int          busy_len;
    } exp_t;

    exp_t q_exp[$];
    int   cyc      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   busy_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset || !busy) busy_run = 0;
        else busy_run++;
        if (done) begin
            if (q_exp.size() == 0) begin
                check("unexpected_done", 32'(out_v), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("result", 32'(out_v), 32'(e.res));
                check("done_latency", 32'(cyc), 32'(e.done_cyc));
                check("busy_length", 32'(busy_run), 32'(e.busy_len));
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [1:0] sh, input logic [3:0] amt,
                         input logic [15:0] res, input bit push);
        int n;
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        in_v     = a;
        shift_v  = sh;
        amount_v = amt;
        n = ((amt == 4'd0) || (sh == 2'b00)) ? 0 : int'(amt);
        if (push) begin
            e.res      = res;
            e.done_cyc = cyc + 1 + n;
            e.busy_len = n + 1;
            q_exp.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [1:0] sh, input logic [3:0] amt,
                          input logic [15:0] res);
        issue(a, sh, amt, res, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_v     = '0;
        shift_v  = '0;
        amount_v = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_out", 32'(out_v), 32'h0000);
        end

        run_op(16'hFDC9, 2'b10, 4'd4,  16'h0FDC);
        run_op(16'hFDC9, 2'b11, 4'd4,  16'hFFDC);
        run_op(16'hFDC9, 2'b01, 4'd4,  16'hDC90);
        check("idle_hold_out", 32'(out_v), 32'h0000_DC90);
        run_op(16'h0001, 2'b01, 4'd15, 16'h8000);
        run_op(16'h8000, 2'b11, 4'd15, 16'hFFFF);
        run_op(16'h1234, 2'b01, 4'd0,  16'h1234);
        run_op(16'h1234, 2'b00, 4'd7,  16'h1234);

        // Re-pulses during SHIFT and on the done cycle must be dropped.
        issue(16'hFDC9, 2'b10, 4'd4, 16'h0FDC, 1'b1);
        @(negedge clk);
        start = 1'b1; in_v = 16'hFFFF; shift_v = 2'b01; amount_v = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1; in_v = 16'h5555; shift_v = 2'b11; amount_v = 4'd2;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_out", 32'(out_v), 32'h0FDC);
        run_op(16'h00F0, 2'b10, 4'd3, 16'h001E);

        // Reset landing on the second shift edge of an 8-step operation.
        issue(16'h00FF, 2'b01, 4'd8, 16'h0000, 1'b0);
        @(negedge clk);
        check("abort_mid_out", 32'(out_v), 32'h01FE);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out", 32'(out_v), 32'h0000);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(16'h0F0F, 2'b01, 4'd8, 16'h0F00);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_sequencer

`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-bit shift controller built around the existing single-step 16-bit `shifter` datapath block.
- Accepts a one-cycle request carrying an operand, a 2-bit shift code and a 4-bit shift amount.
- Drives the operand through the `shifter` once per clock for the requested number of steps, then reports the result with a one-cycle done pulse.
- Gives the datapath shifts of 0–15 positions without a barrel shifter.

Parameters:
- WIDTH, 16, operand width; must equal the `shifter` width (16).
- AMT_W, 4, width of the shift-amount field; maximum amount is 2**AMT_W-1 (15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- in  input  WIDTH  operand, captured on the accepted start.
- shift  input  2  op code: 00 none, 01 left (LSB fill 0), 10 logical right (MSB fill 0), 11 arithmetic right (MSB copied).
- amount  input  AMT_W  number of single-step shifts.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; `out` is valid while done=1.
- out  output  WIDTH  accumulator register value.

Behaviour:
- State is registered (IDLE, SHIFT, DONE); all outputs are Moore, decoded from registered state and the accumulator.
- Reset (sync, active-high): state=IDLE, acc=0, cnt=0, op=00. Outputs after reset: busy=0, done=0, out=0.
- Reset asserted mid-operation aborts the operation at the next edge: no done pulse, acc cleared.
- IDLE, start=1 at edge E0: acc<=in, op<=shift, cnt<=amount.
  - If amount==0 or shift==00: next state DONE.
  - Otherwise: next state SHIFT.
- IDLE, start=0: hold all state. out keeps the last result.
- SHIFT, each edge:
  - acc<=shifter(acc, op); cnt<=cnt-1.
  - If cnt==1 at that edge: next state DONE. Otherwise stay in SHIFT.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- Latency:
  - For N=amount>0 and op!=00, acc is updated on edges E1..EN. done is high in the cycle after edge EN (N+1 cycles after the start cycle).
  - For N=0 or op=00, done is high in the cycle after E0. out equals `in` unchanged.
- start while busy=1 is ignored: no queuing, and in/shift/amount changes have no effect.
- start sampled in the same cycle that done=1 is ignored, because the state is DONE, not IDLE. A new request is accepted no earlier than the first IDLE cycle.
- out continuously reflects acc:
  - It shows intermediate values during SHIFT.
  - Consumers use it only when done=1.
  - It holds its value in IDLE until the next accepted start.
- Width rules:
  - Bits shifted out are discarded.
  - Arithmetic right copies the MSB each step, so a negative operand converges to all-ones (0xFFFF) and a positive one to 0.
  - cnt never underflows: SHIFT exits at cnt==1.
- The op code is held in a register for the whole operation. The shifter control input is the registered op, never the live `shift` port.

Decomposition:
- Package shift_pkg:
  - localparams SH_NONE=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11.
  - State typedef (IDLE, SHIFT, DONE).
  - WIDTH default.
- Sub-module: one instance of the existing combinational `shifter` (in, shift, out), fed from acc and the registered op. No other sub-modules.
- Controller FSM, counter and accumulator live in shift_sequencer.

Test Plan:
- Reset, then idle with start=0 -> busy=0, done=0, out=0x0000 for 5 cycles.
- in=0xFDC9, shift=10, amount=4, start pulse -> busy 5 cycles; done in the cycle after the 4th shift edge; out=0x0FDC.
- in=0xFDC9, shift=11, amount=4 -> out=0xFFDC. Then in=0xFDC9, shift=01, amount=4 -> out=0xDC90.
- Boundaries:
  - in=0x0001, shift=01, amount=15 -> out=0x8000 after 15 shift edges.
  - in=0x8000, shift=11, amount=15 -> out=0xFFFF.
  - amount=0 or shift=00 with in=0x1234 -> done one cycle after start, out=0x1234.
- start re-pulsed with different in/shift/amount during SHIFT and on the done cycle -> ignored; original result 0x0FDC delivered; next start accepted only from IDLE.
- reset asserted at the 2nd shift edge of an amount=8 operation -> no done pulse, out=0, busy=0; a subsequent request completes correctly.
